// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with hazard-unit stall/flush control
// and saturating stall/flush event counters for performance debug.
module pipe_stage_reg #(
    parameter int              DW            = 32,
    parameter int              PCW           = 32,
    parameter logic [DW-1:0]   NOP_WORD      = '0,
    parameter bit              FLUSH_KEEP_PC = 1'b0,
    parameter int              CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [DW-1:0]    instr_i,
    input  logic [PCW-1:0]   pc_i,
    input  logic             valid_i,
    input  logic             cnt_clr,
    output logic [DW-1:0]    instr_o,
    output logic [PCW-1:0]   pc_o,
    output logic             valid_o,
    output logic             held_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [DW-1:0]    instr_q, instr_d;
    logic [PCW-1:0]   pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_ev;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // A flush wins over a stall, so a simultaneous request is counted only as a flush.
    assign stall_ev = !flush && !en;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        held_d  = 1'b0;
        if (flush) begin
            instr_d = NOP_WORD;
            pc_d    = FLUSH_KEEP_PC ? pc_i : '0;
            valid_d = 1'b0;
        end else if (!en) begin
            held_d  = 1'b1;
        end else begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = valid_i;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_ev) stall_cnt_d = sat_inc(stall_cnt_q);
            if (flush)    flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q     <= NOP_WORD;
            pc_q        <= '0;
            valid_q     <= 1'b0;
            held_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            held_q      <= held_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign valid_o   = valid_q;
    assign held_o    = held_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register, successor to the fixed 32-bit IF/ID latch. Used for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.
- Carries an instruction word, a PC value and a valid bit.
- Supports hazard-unit stall (hold) and flush (bubble insertion), with an optional flush mode that keeps the PC.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- DW, 32, instruction/payload width in bits.
- PCW, 32, PC field width in bits.
- NOP_WORD, 0, payload value loaded on flush and reset (`sll $0,$0,0`).
- FLUSH_KEEP_PC, 0, 1 = flush loads pc_i into pc_o; 0 = flush clears pc_o to 0.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high reset.
- en, input, 1, stage load enable from the hazard unit; 0 = stall (hold contents).
- flush, input, 1, replace the stage contents with a bubble on the next edge.
- instr_i, input, DW, incoming instruction/payload.
- pc_i, input, PCW, incoming PC (or PC+4) value.
- valid_i, input, 1, incoming slot holds a real instruction.
- instr_o, output, DW, registered payload.
- pc_o, output, PCW, registered PC.
- valid_o, output, 1, registered valid.
- held_o, output, 1, 1 when the previous edge was a stall (contents were held).
- stall_cnt, output, CNT_W, count of stall edges, saturating.
- flush_cnt, output, CNT_W, count of flush edges, saturating.
- cnt_clr, input, 1, synchronous clear of both counters.

Behaviour:
- All state updates on the rising edge of clk. Every output is registered; no combinational path from inputs to outputs.
- Reset (highest priority, synchronous, active-high):
  - instr_o = NOP_WORD, pc_o = 0, valid_o = 0, held_o = 0.
  - stall_cnt = 0, flush_cnt = 0.
  - Reset asserted in the middle of a stall or flush overrides both; the first edge after deassertion behaves normally.
- Per-edge action priority when reset = 0: flush > stall > load.
  - Flush (flush = 1, regardless of en):
    - instr_o = NOP_WORD, valid_o = 0, held_o = 0.
    - pc_o = pc_i if FLUSH_KEEP_PC = 1, else 0.
    - flush_cnt increments.
  - Stall (flush = 0, en = 0): instr_o, pc_o and valid_o hold; held_o = 1; stall_cnt increments.
  - Load (flush = 0, en = 1): instr_o = instr_i, pc_o = pc_i, valid_o = valid_i, held_o = 0.
- Latency: one cycle from input to output on load. Consecutive stalls hold indefinitely.
- Counters:
  - Saturate at 2^CNT_W - 1; no wrap.
  - cnt_clr = 1 zeroes both counters on that edge.
  - cnt_clr takes priority over an increment on the same edge.
  - cnt_clr does not affect the data path.
- Simultaneous stall and flush: counts as a flush only; stall_cnt does not increment.
- valid_i = 0 with en = 1 is a legal load. The payload is copied as-is; downstream stages treat it as a bubble via valid_o.
- Widths: DW and PCW are independent, both ≥ 1. NOP_WORD is truncated or zero-extended to DW.

Test Plan:
- Reset, then 3 edges with reset = 1 while en = 1 and instr_i = 0x8C080004: all outputs stay at reset values. After deassertion, instr_i = 0x8C080004, pc_i = 0x3004, valid_i = 1, en = 1 → one edge later instr_o = 0x8C080004, pc_o = 0x3004, valid_o = 1, held_o = 0.
- Load 0x00851020 / 0x3008, then en = 0 for 4 edges while instr_i changes every cycle → outputs hold 0x00851020 / 0x3008, held_o = 1 from the first stall edge, stall_cnt = 4.
- flush = 1 and en = 0 together, pc_i = 0x300C:
  - FLUSH_KEEP_PC = 0 → instr_o = 0, pc_o = 0, valid_o = 0, flush_cnt = 1, stall_cnt unchanged.
  - FLUSH_KEEP_PC = 1 → pc_o = 0x300C.
- CNT_W = 2: apply 6 stall edges → stall_cnt reads 1, 2, 3, 3, 3, 3. Then cnt_clr = 1 together with a stall → stall_cnt = 0 and outputs still held.
- DW = 64, PCW = 30, NOP_WORD = 64'hFFFF: load 64'h0123_4567_89AB_CDEF → instr_o matches exactly. Then flush → instr_o = 64'h0000_0000_0000_FFFF.
- Reset asserted on the same edge as flush = 1 and en = 0 → reset values on all outputs and counters = 0.
